larpix_piso_rx: RTL and testbench

Testbench-side UART receiver that sits directly downstream of the LArPix chip model's `piso` lanes. One instance per lane.

- Deframes the start/64-bit/stop serial stream.
- Checks LArPix odd parity on each packet.
- Presents each complete packet on a valid/ready interface to the packet scoreboard.
- Flags framing, parity and overrun events.

---
 rtl/larpix_piso_rx.sv | 182 ++++++++++++++++++
 tb/tb_larpix_piso_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/larpix_piso_rx.sv
// UART receiver for one LArPix piso lane: deframes start/WIDTH/stop frames,
// checks odd parity and hands packets to a valid/ready consumer.
module larpix_piso_rx #(
  parameter int OVERSAMPLE = 4,
  parameter int WIDTH      = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  output logic [WIDTH-1:0] packet_out,
  output logic             packet_valid,
  input  logic             packet_ready,
  output logic             parity_error,
  output logic             framing_error,
  output logic             overrun,
  output logic [15:0]      packet_count
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("larpix_piso_rx: OVERSAMPLE must be even and at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // LArPix packets carry odd parity; an even count of ones is an error.
  function automatic logic odd_parity_err(input logic [WIDTH-1:0] p);
    return ~(^p);
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic              rx_prev_q, rx_prev_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  packet_q, packet_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic [15:0]       count_q, count_d;

  logic rx_s, fall_s, deliver_s, frame_err_s, accept_s, load_s;

  // Frame FSM: synchronizer, bit timing, deserialization.
  always_comb begin
    sync_d      = {sync_q[0], rx_in};
    rx_s        = sync_q[1];
    rx_prev_d   = rx_s;
    fall_s      = rx_prev_q & ~rx_s;
    state_d     = state_q;
    timer_d     = timer_q + TW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    deliver_s   = 1'b0;
    frame_err_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (fall_s) state_d = S_START;
        else        state_d = S_IDLE;
      end
      S_START: begin
        if (timer_q == HALF_M1) begin
          timer_d   = '0;
          bit_idx_d = '0;
          if (!rx_s) state_d = S_DATA;
          else       state_d = S_IDLE;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[WIDTH-1:1]};
          if (bit_idx_q == LAST_BIT) state_d = S_STOP;
          else                       bit_idx_d = bit_idx_q + BW'(1);
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          if (rx_s) begin
            deliver_s = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_s = 1'b1;
            shift_d     = '0;
            state_d     = S_BREAK;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      S_BREAK: begin
        timer_d = '0;
        if (rx_s) state_d = S_IDLE;
        else      state_d = S_BREAK;
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Holding register: a same-cycle accept frees the slot for a new load.
  always_comb begin
    accept_s = valid_q & packet_ready;
    load_s   = deliver_s & (~valid_q | accept_s);
    packet_d = packet_q;
    perr_d   = perr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (load_s) begin
      packet_d = shift_q;
      perr_d   = odd_parity_err(shift_q);
      count_d  = count_q + 16'd1;
      valid_d  = 1'b1;
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    ferr_d = frame_err_s;
    ovr_d  = deliver_s & ~load_s;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      packet_q  <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      rx_prev_q <= rx_prev_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      packet_q  <= packet_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      count_q   <= count_d;
    end
  end

  assign packet_out    = packet_q;
  assign packet_valid  = valid_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign overrun       = ovr_q;
  assign packet_count  = count_q;

endmodule

// File: tb/tb_larpix_piso_rx.sv
// Directed bench for larpix_piso_rx at OVERSAMPLE=4, WIDTH=64.
module tb_larpix_piso_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_in;
  logic        packet_ready;
  logic [63:0] packet_out;
  logic        packet_valid;
  logic        parity_error;
  logic        framing_error;
  logic        overrun;
  logic [15:0] packet_count;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe_base;
  int ov_base;

  larpix_piso_rx #(.OVERSAMPLE(4), .WIDTH(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .packet_out   (packet_out),
    .packet_valid (packet_valid),
    .packet_ready (packet_ready),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .overrun      (overrun),
    .packet_count (packet_count)
  );

  always #5 clk = ~clk;

  // Pulse counters for the one-cycle flags.
  always @(negedge clk) begin
    if (framing_error) fe_cnt <= fe_cnt + 1;
    if (overrun)       ov_cnt <= ov_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends nsym symbols (start, 64 data LSB-first, stop) of 4 clocks each.
  task automatic send_frame(input logic [63:0] d, input logic stop_bit, input int nsym);
    for (int k = 0; k < nsym; k++) begin
      if (k == 0)       rx_in = 1'b0;
      else if (k <= 64) rx_in = d[k-1];
      else              rx_in = stop_bit;
      tick(4);
    end
    rx_in = 1'b1;
  endtask

  initial begin
    reset        = 1'b1;
    rx_in        = 1'b1;
    packet_ready = 1'b0;
    tick(3);
    check_eq("rst_pkt",   packet_out, 64'h0);
    check_eq("rst_valid", {63'h0, packet_valid}, 64'h0);
    check_eq("rst_perr",  {63'h0, parity_error}, 64'h0);
    check_eq("rst_ferr",  {63'h0, framing_error}, 64'h0);
    check_eq("rst_ovr",   {63'h0, overrun}, 64'h0);
    check_eq("rst_cnt",   {48'h0, packet_count}, 64'h0);
    reset = 1'b0;
    tick(5);

    // Single packet, even parity, latency of 265 cycles from the start edge.
    packet_ready = 1'b1;
    send_frame(64'h0123_4567_89AB_CDEF, 1'b1, 66);
    check_eq("lat_264_low", {63'h0, packet_valid}, 64'h0);
    tick(1);
    check_eq("lat_265_high", {63'h0, packet_valid}, 64'h1);
    check_eq("p1_data", packet_out, 64'h0123_4567_89AB_CDEF);
    check_eq("p1_perr", {63'h0, parity_error}, 64'h1);
    check_eq("p1_cnt",  {48'h0, packet_count}, 64'd1);
    tick(1);
    check_eq("p1_accept_drop", {63'h0, packet_valid}, 64'h0);

    // Odd parity packet.
    tick(10);
    send_frame(64'h8000_0000_0000_0000, 1'b1, 66);
    tick(2);
    check_eq("p2_data", packet_out, 64'h8000_0000_0000_0000);
    check_eq("p2_perr", {63'h0, parity_error}, 64'h0);
    check_eq("p2_cnt",  {48'h0, packet_count}, 64'd2);

    // Three back-to-back frames with the consumer stalled.
    tick(10);
    packet_ready = 1'b0;
    ov_base = ov_cnt;
    send_frame(64'h0000_0000_0000_0001, 1'b1, 66);
    send_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 66);
    send_frame(64'h5555_5555_5555_5555, 1'b1, 66);
    tick(3);
    check_eq("b2b_held",  packet_out, 64'h0000_0000_0000_0001);
    check_eq("b2b_perr",  {63'h0, parity_error}, 64'h0);
    check_eq("b2b_valid", {63'h0, packet_valid}, 64'h1);
    check_eq("b2b_ovr2",  64'(ov_cnt - ov_base), 64'd2);
    check_eq("b2b_cnt",   {48'h0, packet_count}, 64'd3);
    packet_ready = 1'b1;
    tick(1);
    check_eq("b2b_accept", {63'h0, packet_valid}, 64'h0);

    // Low stop bit followed by a long break, then a good frame.
    tick(10);
    fe_base = fe_cnt;
    send_frame(64'h1234_0000_0000_4321, 1'b0, 66);
    rx_in = 1'b0;
    tick(5);
    check_eq("fe_pulse",    64'(fe_cnt - fe_base), 64'd1);
    check_eq("fe_no_valid", {63'h0, packet_valid}, 64'h0);
    check_eq("fe_cnt_hold", {48'h0, packet_count}, 64'd3);
    tick(495);
    rx_in = 1'b1;
    tick(20);
    check_eq("fe_once", 64'(fe_cnt - fe_base), 64'd1);
    send_frame(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 66);
    tick(2);
    check_eq("fe_next_data", packet_out, 64'hDEAD_BEEF_CAFE_F00D);
    check_eq("fe_next_perr", {63'h0, parity_error}, 64'h1);
    check_eq("fe_next_cnt",  {48'h0, packet_count}, 64'd4);

    // One-cycle glitch on an idle line.
    tick(10);
    fe_base = fe_cnt;
    ov_base = ov_cnt;
    rx_in = 1'b0;
    tick(1);
    rx_in = 1'b1;
    tick(20);
    check_eq("gl_ferr",  64'(fe_cnt - fe_base), 64'd0);
    check_eq("gl_ovr",   64'(ov_cnt - ov_base), 64'd0);
    check_eq("gl_valid", {63'h0, packet_valid}, 64'h0);
    check_eq("gl_cnt",   {48'h0, packet_count}, 64'd4);
    check_eq("gl_pkt",   packet_out, 64'hDEAD_BEEF_CAFE_F00D);
    send_frame(64'h0000_0000_0000_00F1, 1'b1, 66);
    tick(2);
    check_eq("gl_next_data", packet_out, 64'h0000_0000_0000_00F1);
    check_eq("gl_next_perr", {63'h0, parity_error}, 64'h0);
    check_eq("gl_next_cnt",  {48'h0, packet_count}, 64'd5);

    // Reset while data bit 30 is on the wire.
    tick(10);
    send_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 31);
    rx_in = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    check_eq("mr_pkt",   packet_out, 64'h0);
    check_eq("mr_valid", {63'h0, packet_valid}, 64'h0);
    check_eq("mr_perr",  {63'h0, parity_error}, 64'h0);
    check_eq("mr_ferr",  {63'h0, framing_error}, 64'h0);
    check_eq("mr_ovr",   {63'h0, overrun}, 64'h0);
    check_eq("mr_cnt",   {48'h0, packet_count}, 64'h0);
    reset = 1'b0;
    rx_in = 1'b1;
    tick(10);
    send_frame(64'h0000_0000_0000_0007, 1'b1, 66);
    tick(2);
    check_eq("mr_next_data", packet_out, 64'h0000_0000_0000_0007);
    check_eq("mr_next_perr", {63'h0, parity_error}, 64'h0);
    check_eq("mr_next_cnt",  {48'h0, packet_count}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
